// File: rtl/float_mul_pipe.sv
`timescale 1ns/1ps
// float_mul_pipe: three-stage pipelined, multi-lane floating-point multiplier.
// Round-to-nearest-even, flush-to-zero of subnormals, canonical quiet NaN,
// per-lane enable mask and valid/ready streaming with whole-pipe stall.
// Optional macro FLOAT_MUL_EXC_FLAGS_EN adds per-lane exception flags
// {invalid, overflow, underflow, inexact} on out_flags.
module float_mul_pipe #(
    parameter  int EXP_WIDTH = 8,
    parameter  int MAN_WIDTH = 7,
    parameter  int BIAS      = -127,
    parameter  int LANES     = 4,
    localparam int W         = EXP_WIDTH + MAN_WIDTH + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_lhs,
    input  logic [LANES*W-1:0] in_rhs,
    input  logic [LANES-1:0]   in_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_res
`ifdef FLOAT_MUL_EXC_FLAGS_EN
    ,
    output logic [LANES*4-1:0] out_flags
`endif
);

    localparam int EW2 = EXP_WIDTH + 2;
    localparam int MW1 = MAN_WIDTH + 1;
    localparam int PW  = 2 * MW1;

    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    logic                w_advance;

    logic                w_s1_sign [LANES];
    kind_t               w_s1_kind [LANES];
    logic [EW2-1:0]      w_s1_exp  [LANES];
    logic [MW1-1:0]      w_s1_ma   [LANES];
    logic [MW1-1:0]      w_s1_mb   [LANES];

    logic                r_s1_valid;
    logic [LANES-1:0]    r_s1_mask;
    logic                r_s1_sign [LANES];
    kind_t               r_s1_kind [LANES];
    logic [EW2-1:0]      r_s1_exp  [LANES];
    logic [MW1-1:0]      r_s1_ma   [LANES];
    logic [MW1-1:0]      r_s1_mb   [LANES];

    logic                r_s2_valid;
    logic [LANES-1:0]    r_s2_mask;
    logic                r_s2_sign [LANES];
    kind_t               r_s2_kind [LANES];
    logic [EW2-1:0]      r_s2_exp  [LANES];
    logic [PW-1:0]       r_s2_prod [LANES];

    logic [W-1:0]        w_res     [LANES];
    logic                r_out_valid;
    logic [LANES*W-1:0]  r_out_res;
`ifdef FLOAT_MUL_EXC_FLAGS_EN
    logic [3:0]          w_flags   [LANES];
    logic [LANES*4-1:0]  r_out_flags;
`endif

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
`ifdef FLOAT_MUL_EXC_FLAGS_EN
    assign out_flags = r_out_flags;
`endif

    // Stage 1 logic: unpack operands, classify specials, sum exponents with bias.
    always_comb begin
        logic [W-1:0]         a, b;
        logic [EXP_WIDTH-1:0] ea, eb;
        logic [MAN_WIDTH-1:0] ma, mb;
        logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        for (int unsigned i = 0; i < LANES; i++) begin
            a      = in_lhs[i*W +: W];
            b      = in_rhs[i*W +: W];
            ea     = a[W-2 -: EXP_WIDTH];
            eb     = b[W-2 -: EXP_WIDTH];
            ma     = a[MAN_WIDTH-1:0];
            mb     = b[MAN_WIDTH-1:0];
            a_nan  = (&ea) & (|ma);
            b_nan  = (&eb) & (|mb);
            a_inf  = (&ea) & ~(|ma);
            b_inf  = (&eb) & ~(|mb);
            a_zero = ~(|ea);
            b_zero = ~(|eb);
            w_s1_sign[i] = a[W-1] ^ b[W-1];
            w_s1_exp[i]  = EW2'(int'(ea) + int'(eb) + BIAS);
            w_s1_ma[i]   = {1'b1, ma};
            w_s1_mb[i]   = {1'b1, mb};
            if (a_nan || b_nan)
                w_s1_kind[i] = K_NAN;
            else if ((a_inf && b_zero) || (b_inf && a_zero))
                w_s1_kind[i] = K_NAN;
            else if (a_inf || b_inf)
                w_s1_kind[i] = K_INF;
            else if (a_zero || b_zero)
                w_s1_kind[i] = K_ZERO;
            else
                w_s1_kind[i] = K_NORM;
        end
    end

    // Stage 3 logic: normalise, round to nearest even, detect range, pack.
    always_comb begin
        logic [PW-1:0]        pn;
        logic                 norm, guard, sticky, inc, ovf, unf;
        logic [MAN_WIDTH-1:0] man;
        logic [MW1-1:0]       man_r;
        logic [EW2-1:0]       e_fin;
        for (int unsigned i = 0; i < LANES; i++) begin
            norm   = r_s2_prod[i][PW-1];
            // Left-align the product so the hidden bit always sits at PW-1.
            pn     = norm ? r_s2_prod[i] : (r_s2_prod[i] << 1);
            man    = pn[PW-2 -: MAN_WIDTH];
            guard  = pn[MAN_WIDTH];
            sticky = |pn[MAN_WIDTH-1:0];
            inc    = guard & (sticky | man[0]);
            man_r  = {1'b0, man} + MW1'(inc);
            e_fin  = r_s2_exp[i] + EW2'(norm) + EW2'(man_r[MAN_WIDTH]);
            ovf    = $signed(e_fin) >= $signed(EW2'((1 << EXP_WIDTH) - 1));
            unf    = $signed(e_fin) < $signed(EW2'(1));
            w_res[i] = '0;
`ifdef FLOAT_MUL_EXC_FLAGS_EN
            w_flags[i] = '0;
`endif
            if (r_s2_mask[i]) begin
                case (r_s2_kind[i])
                    K_NAN: begin
                        w_res[i] = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
`ifdef FLOAT_MUL_EXC_FLAGS_EN
                        w_flags[i] = 4'b1000;
`endif
                    end
                    K_INF:  w_res[i] = {r_s2_sign[i], {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                    K_ZERO: w_res[i] = {r_s2_sign[i], {(W-1){1'b0}}};
                    default: begin
                        if (ovf) begin
                            w_res[i] = {r_s2_sign[i], {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
`ifdef FLOAT_MUL_EXC_FLAGS_EN
                            w_flags[i] = 4'b0101;
`endif
                        end else if (unf) begin
                            w_res[i] = {r_s2_sign[i], {(W-1){1'b0}}};
`ifdef FLOAT_MUL_EXC_FLAGS_EN
                            w_flags[i] = 4'b0011;
`endif
                        end else begin
                            w_res[i] = {r_s2_sign[i], e_fin[EXP_WIDTH-1:0], man_r[MAN_WIDTH-1:0]};
`ifdef FLOAT_MUL_EXC_FLAGS_EN
                            w_flags[i] = {3'b000, guard | sticky};
`endif
                        end
                    end
                endcase
            end
        end
    end

    // Pipeline registers: all stages advance together or freeze together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_s1_mask   <= '0;
            r_s2_mask   <= '0;
            r_out_res   <= '0;
`ifdef FLOAT_MUL_EXC_FLAGS_EN
            r_out_flags <= '0;
`endif
            for (int unsigned i = 0; i < LANES; i++) begin
                r_s1_sign[i] <= 1'b0;
                r_s1_kind[i] <= K_NORM;
                r_s1_exp[i]  <= '0;
                r_s1_ma[i]   <= '0;
                r_s1_mb[i]   <= '0;
                r_s2_sign[i] <= 1'b0;
                r_s2_kind[i] <= K_NORM;
                r_s2_exp[i]  <= '0;
                r_s2_prod[i] <= '0;
            end
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_s1_mask   <= in_mask;
            r_s2_valid  <= r_s1_valid;
            r_s2_mask   <= r_s1_mask;
            r_out_valid <= r_s2_valid;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_s1_sign[i] <= w_s1_sign[i];
                r_s1_kind[i] <= w_s1_kind[i];
                r_s1_exp[i]  <= w_s1_exp[i];
                r_s1_ma[i]   <= w_s1_ma[i];
                r_s1_mb[i]   <= w_s1_mb[i];
                r_s2_sign[i] <= r_s1_sign[i];
                r_s2_kind[i] <= r_s1_kind[i];
                r_s2_exp[i]  <= r_s1_exp[i];
                r_s2_prod[i] <= r_s1_ma[i] * r_s1_mb[i];
                r_out_res[i*W +: W] <= w_res[i];
`ifdef FLOAT_MUL_EXC_FLAGS_EN
                r_out_flags[i*4 +: 4] <= w_flags[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_float_mul_pipe.sv
`timescale 1ns/1ps
// tb_float_mul_pipe: directed-vector bench for float_mul_pipe (bf16, 4 lanes).
module tb_float_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_lhs = '0;
    logic [63:0] in_rhs = '0;
    logic [3:0]  in_mask = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_res;
`ifdef FLOAT_MUL_EXC_FLAGS_EN
    logic [15:0] out_flags;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    float_mul_pipe #(
        .EXP_WIDTH(8),
        .MAN_WIDTH(7),
        .BIAS(-127),
        .LANES(4)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_lhs(in_lhs),
        .in_rhs(in_rhs),
        .in_mask(in_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res(out_res)
`ifdef FLOAT_MUL_EXC_FLAGS_EN
        ,
        .out_flags(out_flags)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One beat, same operands on every lane; checks exact 3-cycle latency and single pulse.
    task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] mask, input logic [63:0] eres,
                           input logic [15:0] eflags);
        out_ready = 1'b1;
        in_lhs    = {4{a}};
        in_rhs    = {4{b}};
        in_mask   = mask;
        in_valid  = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        tick;
        chk({tag, "_lat2"}, out_valid, 0);
        tick;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_res"}, out_res, eres);
`ifdef FLOAT_MUL_EXC_FLAGS_EN
        chk({tag, "_flags"}, out_flags, eflags);
`endif
        tick;
        chk({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_q[$];
        logic [15:0] bp_val[6];
        logic [3:0]  pat;
        logic        held_v;
        logic [63:0] held_r;
        int          sent, got, cyc;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 64'h0);
        chk("rst_in_ready", in_ready, 1);
`ifdef FLOAT_MUL_EXC_FLAGS_EN
        chk("rst_flags", out_flags, 16'h0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        // Main function and boundaries
        run_vec("basic",   16'h3FC0, 16'h3FC0, 4'hF, {4{16'h4010}}, 16'h0000);
        run_vec("rnd_up",  16'h3F81, 16'h3F81, 4'hF, {4{16'h3F82}}, 16'h1111);
        run_vec("rnd_tie", 16'h3F81, 16'h3FC0, 4'hF, {4{16'h3FC2}}, 16'h1111);
        run_vec("ovf",     16'h7F00, 16'h4000, 4'hF, {4{16'h7F80}}, 16'h5555);
        run_vec("inf_x0",  16'h7F80, 16'h0000, 4'hF, {4{16'h7FC0}}, 16'h8888);
        run_vec("ninf_x1", 16'hFF80, 16'h3F80, 4'hF, {4{16'hFF80}}, 16'h0000);
        run_vec("sub_ftz", 16'h0001, 16'h4000, 4'hF, {4{16'h0000}}, 16'h0000);
        run_vec("unf",     16'h0080, 16'h3F00, 4'hF, {4{16'h0000}}, 16'h3333);
        run_vec("nan_in",  16'h7FC1, 16'h3F80, 4'hF, {4{16'h7FC0}}, 16'h8888);
        run_vec("neg",     16'hC000, 16'h4000, 4'hF, {4{16'hC080}}, 16'h0000);
        run_vec("mask",    16'h4000, 16'h4000, 4'b0101,
                {16'h0000, 16'h4080, 16'h0000, 16'h4080}, 16'h0000);

        // Backpressure: out_ready pattern 1,0,0,1 repeating, 6 beats streamed
        bp_val = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0};
        pat    = 4'b1001;
        held_v = 1'b0;
        held_r = '0;
        sent   = 0;
        got    = 0;
        cyc    = 0;
        in_mask = 4'hF;
        in_lhs  = {4{16'h3F80}};
        while (got < 6 && cyc < 100) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 6);
            if (sent < 6)
                for (int l = 0; l < 4; l++) in_rhs[l*16 +: 16] = bp_val[sent] + 16'(l);
            #1;
            chk("bp_in_ready", in_ready, !out_valid || out_ready);
            if (held_v) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_res", out_res, held_r);
            end
            if (out_valid && out_ready) begin
                chk("bp_not_extra", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("bp_order", out_res, exp_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_rhs);
                sent++;
            end
            held_v = out_valid && !out_ready;
            held_r = out_res;
            tick;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_out", got, 6);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("bp_no_dup", out_valid, 0);
        end

        // Reset mid-flight: three beats accepted, reset while first is at the output
        in_lhs   = {4{16'h4000}};
        in_rhs   = {4{16'h4000}};
        in_mask  = 4'hF;
        in_valid = 1'b1;
        tick;
        tick;
        tick;
        in_valid = 1'b0;
        chk("rmf_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rmf_valid_now", out_valid, 0);
        chk("rmf_res_now", out_res, 64'h0);
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rmf_no_stale", out_valid, 0);
        end
        run_vec("post_rst", 16'h4000, 16'h4000, 4'hF, {4{16'h4080}}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
